// File: rtl/clk_rst_seq.sv
// clk_rst_seq: multi-channel clock-enable and reset sequencer.
// After a global reset the active-low channel resets are released one by one,
// with a fixed stagger between channels. Each released channel then produces a
// divided one-cycle clock-enable pulse train. An end-of-simulation request
// drains every channel to a clean stop.
//
// Build macro CLK_RST_SEQ_CYCLE_CNT_EN: when defined, Cycles_DO counts the
// cycles spent in RUN or DRAIN (saturating, frozen once stopped). When not
// defined, Cycles_DO is tied to zero.
//
// Stop request protocol: EndOfSim_SI is a level. The first clock edge that
// samples it high latches a sticky stop flag; later deassertion has no effect.
// A channel whose pulse is present in the same cycle the request is sampled
// treats that pulse as its final one. Rst_SI always takes priority.
module clk_rst_seq #(
    parameter int N_CHAN     = 4,
    parameter int RST_CYCLES = 16,
    parameter int STAGGER    = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_SI,
    input  logic [N_CHAN*DIV_WIDTH-1:0] Div_DI,
    input  logic                        EndOfSim_SI,
    output logic [N_CHAN-1:0]           ClkEn_SO,
    output logic [N_CHAN-1:0]           Rst_RBO,
    output logic                        Done_SO,
    output logic [CNT_WIDTH-1:0]        Cycles_DO
);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_STOPPED  = 3'd4
    } state_e;

    // Cycle index of the last channel release; must fit in the sequence counter.
    localparam longint LAST_REL = longint'(RST_CYCLES) + longint'(N_CHAN - 1) * longint'(STAGGER);

    if (N_CHAN < 1 || N_CHAN > 16) begin : g_bad_nchan
        $error("clk_rst_seq: N_CHAN=%0d outside 1..16", N_CHAN);
    end
    if (CNT_WIDTH < 63 && LAST_REL >= (longint'(1) << CNT_WIDTH)) begin : g_bad_cnt
        $error("clk_rst_seq: last release cycle %0d does not fit CNT_WIDTH=%0d", LAST_REL, CNT_WIDTH);
    end

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   seq_q, seq_d;
    logic                   stop_q, stop_d;
    logic                   stop_now;
    logic [N_CHAN-1:0]      rst_rb_q, rst_rb_d;
    logic [N_CHAN-1:0]      fin_q, fin_d;
    logic [N_CHAN-1:0]      clken_q, clken_d;
    logic                   done_q, done_d;
    logic                   all_fin;
    logic [DIV_WIDTH-1:0]   cnt_q  [N_CHAN];
    logic [DIV_WIDTH-1:0]   cnt_d  [N_CHAN];
    logic [DIV_WIDTH-1:0]   shad_q [N_CHAN];
    logic [DIV_WIDTH-1:0]   shad_d [N_CHAN];

    // Next-state: sequence counter, channel release, dividers, drain and FSM.
    always_comb begin
        stop_now = stop_q | EndOfSim_SI;
        stop_d   = stop_now;
        seq_d    = (seq_q == '1) ? seq_q : seq_q + 1'b1;
        rst_rb_d = rst_rb_q;
        fin_d    = fin_q;
        clken_d  = '0;
        cnt_d    = cnt_q;
        shad_d   = shad_q;
        state_d  = state_q;

        for (int i = 0; i < N_CHAN; i++) begin
            if (state_q != ST_STOPPED) begin
                if (!rst_rb_q[i]) begin
                    // Release lands on cycle RST_CYCLES+i*STAGGER; a pending stop cancels it for good.
                    if (!stop_now && seq_q == CNT_WIDTH'(RST_CYCLES + i * STAGGER - 1)) begin
                        rst_rb_d[i] = 1'b1;
                        cnt_d[i]    = '0;
                        shad_d[i]   = Div_DI[i*DIV_WIDTH +: DIV_WIDTH];
                    end
                end else if (!fin_q[i]) begin
                    if (clken_q[i]) begin
                        // Pulse cycle: restart the period with the ratio presented now.
                        cnt_d[i]  = '0;
                        shad_d[i] = Div_DI[i*DIV_WIDTH +: DIV_WIDTH];
                        if (stop_now) begin
                            fin_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end

        // Channels that never got released count as already drained.
        all_fin = &(fin_d | ~rst_rb_d);

        case (state_q)
            ST_STOPPED: state_d = ST_STOPPED;
            ST_HOLD: begin
                if (stop_now)             state_d = ST_STOPPED;
                else if (rst_rb_d[N_CHAN-1]) state_d = ST_RUN;
                else if (rst_rb_d[0])     state_d = ST_RELEASE;
                else                      state_d = ST_HOLD;
            end
            default: begin
                if (stop_now)             state_d = all_fin ? ST_STOPPED : ST_DRAIN;
                else if (rst_rb_d[N_CHAN-1]) state_d = ST_RUN;
                else                      state_d = ST_RELEASE;
            end
        endcase

        for (int i = 0; i < N_CHAN; i++) begin
            clken_d[i] = rst_rb_d[i] & ~fin_d[i] & (cnt_d[i] == shad_d[i]);
        end
        if (state_d == ST_STOPPED) begin
            clken_d = '0;
        end
        done_d = (state_d == ST_STOPPED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk_CI) begin
        if (Rst_SI) begin
            state_q  <= ST_HOLD;
            seq_q    <= '0;
            stop_q   <= 1'b0;
            rst_rb_q <= '0;
            fin_q    <= '0;
            clken_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '{default: '0};
            shad_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            stop_q   <= stop_d;
            rst_rb_q <= rst_rb_d;
            fin_q    <= fin_d;
            clken_q  <= clken_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            shad_q   <= shad_d;
        end
    end

`ifdef CLK_RST_SEQ_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;

    // Count RUN/DRAIN cycles, saturating at all-ones.
    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == ST_RUN || state_q == ST_DRAIN) && cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    // Run-cycle counter register.
    always_ff @(posedge Clk_CI) begin
        if (Rst_SI) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign Cycles_DO = cyc_q;
`else
    assign Cycles_DO = '0;
`endif

    assign ClkEn_SO = clken_q;
    assign Rst_RBO  = rst_rb_q;
    assign Done_SO  = done_q;

endmodule
